// File: rtl/instr_fetch.sv
// Instruction fetch front end: drives a PC into a combinational ROM and queues {pc, instr}
// pairs for the decoder. Optional perf counters are enabled by defining INSTR_FETCH_PERF_EN.
module instr_fetch #(
    parameter int                   PC_WIDTH    = 16,
    parameter int                   INSTR_WIDTH = 10,
    parameter int                   FIFO_DEPTH  = 2,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR = 10'h3FF
) (
    input  logic                          clock,
    input  logic                          reset,
    output logic [PC_WIDTH-1:0]           pc_out,
    input  logic [INSTR_WIDTH-1:0]        instr_in,
    output logic                          fetch_valid,
    output logic [INSTR_WIDTH-1:0]        fetch_instr,
    output logic [PC_WIDTH-1:0]           fetch_pc,
    input  logic                          fetch_ready,
    input  logic                          redirect_valid,
    input  logic [PC_WIDTH-1:0]           redirect_pc,
    output logic                          halted,
`ifdef INSTR_FETCH_PERF_EN
    output logic [31:0]                   perf_fetched,
    output logic [31:0]                   perf_stalls,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = PC_WIDTH + INSTR_WIDTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_halted;
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];

    logic w_empty;
    logic w_deq;
    logic w_enq;
    logic w_is_halt;

    // Decoder handshake: an entry transfers on any edge where fetch_valid and
    // fetch_ready are both high; fetch_valid never depends on fetch_ready.
    assign w_empty   = (r_count == '0);
    assign w_deq     = !w_empty && fetch_ready;
    assign w_enq     = !r_halted && !redirect_valid && ((r_count < DEPTH_C) || w_deq);
    assign w_is_halt = (instr_in == HALT_INSTR);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            // Any head handshake this cycle still completes; everything else is dropped.
            r_pc     <= redirect_pc;
            r_halted <= 1'b0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
        end else begin
            if (w_deq) begin
                r_head <= r_head + PW'(1);
            end
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
                if (w_is_halt) begin
                    r_halted <= 1'b1;
                end else begin
                    r_pc <= r_pc + PC_WIDTH'(1);
                end
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && w_enq) begin
            r_mem[r_tail] <= {r_pc, instr_in};
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalls;
    logic        w_stall;

    assign w_stall = !r_halted && !redirect_valid && !w_enq;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stalls  <= '0;
        end else begin
            if (w_enq && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_stall && (r_perf_stalls != 32'hFFFF_FFFF)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stalls  = r_perf_stalls;
`endif

    // Head fields read as zero while empty so the decoder never sees stale data.
    assign pc_out      = r_pc;
    assign halted      = r_halted;
    assign fifo_count  = r_count;
    assign fetch_valid = !w_empty;
    assign fetch_pc    = w_empty ? '0 : r_mem[r_head][EW-1:INSTR_WIDTH];
    assign fetch_instr = w_empty ? '0 : r_mem[r_head][INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a queue-based reference model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_instr_fetch;

    logic        clock;
    logic        reset;
    logic [15:0] pc_out;
    logic [9:0]  instr_in;
    logic        fetch_valid;
    logic [9:0]  fetch_instr;
    logic [15:0] fetch_pc;
    logic        fetch_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
    logic [1:0]  fifo_count;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
`endif

    int n_vec = 0;
    int n_err = 0;

    instr_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .pc_out         (pc_out),
        .instr_in       (instr_in),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted),
`ifdef INSTR_FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls),
`endif
        .fifo_count     (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [9:0] rom(input logic [15:0] a);
        if (a == 16'd12) return 10'h3FF;
        return a[9:0] ^ 10'h055;
    endfunction

    assign instr_in = rom(pc_out);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of fetched entries, advanced from the fetch rules.
    typedef struct packed {
        logic [15:0] pc;
        logic [9:0]  instr;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] m_pc;
    logic        m_halt;
    bit          model_on = 0;

    always @(posedge clock) begin
        bit   m_deq;
        bit   m_enq;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_pc     = 16'd0;
            m_halt   = 1'b0;
            model_on = 1;
        end else if (model_on) begin
            m_deq = (mq.size() > 0) && fetch_ready;
            m_enq = !m_halt && !redirect_valid && ((mq.size() < 2) || m_deq);
            if (redirect_valid) begin
                mq.delete();
                m_pc   = redirect_pc;
                m_halt = 1'b0;
            end else begin
                if (m_deq) void'(mq.pop_front());
                if (m_enq) begin
                    e.pc    = m_pc;
                    e.instr = rom(m_pc);
                    mq.push_back(e);
                    if (e.instr == 10'h3FF) m_halt = 1'b1;
                    else m_pc = m_pc + 16'd1;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [15:0] hp;
        logic [9:0]  hi;
        if (model_on) begin
            hp = (mq.size() > 0) ? mq[0].pc : 16'd0;
            hi = (mq.size() > 0) ? mq[0].instr : 10'd0;
            chk("model_pc_out", pc_out, m_pc);
            chk("model_valid", fetch_valid, (mq.size() > 0) ? 1 : 0);
            chk("model_count", fifo_count, mq.size());
            chk("model_halted", halted, m_halt);
            chk("model_fetch_pc", fetch_pc, hp);
            chk("model_fetch_instr", fetch_instr, hi);
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk_head(input string name, input logic v, input logic [15:0] p, input logic [9:0] i);
        chk({name, "_valid"}, fetch_valid, v);
        chk({name, "_pc"}, fetch_pc, p);
        chk({name, "_instr"}, fetch_instr, i);
    endtask

    logic [9:0] first_instr [4];

    initial begin
        first_instr[0] = 10'h055;
        first_instr[1] = 10'h054;
        first_instr[2] = 10'h057;
        first_instr[3] = 10'h056;

        reset          = 1'b1;
        fetch_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        step();
        chk("rst_pc_out", pc_out, 16'h0000);
        chk("rst_count", fifo_count, 2'd0);
        chk("rst_halted", halted, 1'b0);
        chk_head("rst_head", 1'b0, 16'h0000, 10'h000);

        // Streaming with ready held high: one entry per cycle.
        reset       = 1'b0;
        fetch_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k < 4) chk_head("stream_lit", 1'b1, 16'(k), first_instr[k]);
            else chk_head("stream", 1'b1, 16'(k), 10'(k) ^ 10'h055);
            chk("stream_pc_out", pc_out, 16'(k + 1));
            chk("stream_count", fifo_count, 2'd1);
        end

        // Backpressure from reset: fill, hold, then drain without gaps.
        reset = 1'b1;
        step();
        reset       = 1'b0;
        fetch_ready = 1'b0;
        step();
        step();
        step();
        chk("full_count", fifo_count, 2'd2);
        chk("full_pc_out", pc_out, 16'h0002);
        chk_head("full_head", 1'b1, 16'h0000, 10'h055);
        fetch_ready = 1'b1;
        step();
        chk_head("drain1", 1'b1, 16'h0001, 10'h054);
        step();
        chk_head("drain2", 1'b1, 16'h0002, 10'h057);
        step();
        chk_head("drain3", 1'b1, 16'h0003, 10'h056);
        chk("drain_pc_out", pc_out, 16'h0005);

        // Run into the HALT at address 12.
        repeat (8) step();
        chk("halt_flag", halted, 1'b1);
        chk("halt_pc_out", pc_out, 16'h000C);
        chk("halt_count", fifo_count, 2'd2);
        chk_head("halt_pre", 1'b1, 16'h000B, 10'h05E);
        step();
        chk_head("halt_entry", 1'b1, 16'h000C, 10'h3FF);
        step();
        chk_head("halt_drained", 1'b0, 16'h0000, 10'h000);
        chk("halt_hold_pc", pc_out, 16'h000C);
        step();
        chk("halt_stay", halted, 1'b1);

        // Leave halt by redirect, fill, then redirect again with a full FIFO.
        fetch_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0050;
        step();
        chk("unhalt_flag", halted, 1'b0);
        chk("unhalt_pc_out", pc_out, 16'h0050);
        redirect_valid = 1'b0;
        step();
        step();
        chk("refill_count", fifo_count, 2'd2);
        chk_head("refill_head", 1'b1, 16'h0050, 10'h005);
        fetch_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        step();
        chk("flush_count", fifo_count, 2'd0);
        chk("flush_valid", fetch_valid, 1'b0);
        chk("flush_pc_out", pc_out, 16'h0100);
        redirect_valid = 1'b0;
        step();
        chk_head("target_head", 1'b1, 16'h0100, 10'h155);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        step();
        chk("wrap_pc_out", pc_out, 16'hFFFE);
        redirect_valid = 1'b0;
        step();
        chk_head("wrap0", 1'b1, 16'hFFFE, 10'h3AB);
        step();
        chk_head("wrap1", 1'b1, 16'hFFFF, 10'h3AA);
        step();
        chk_head("wrap2", 1'b1, 16'h0000, 10'h055);
        step();
        chk_head("wrap3", 1'b1, 16'h0001, 10'h054);

        // Halt with two entries pending, then reset clears everything.
        fetch_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h000B;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        chk("pend_halted", halted, 1'b1);
        chk("pend_count", fifo_count, 2'd2);
        chk_head("pend_head", 1'b1, 16'h000B, 10'h05E);
        reset = 1'b1;
        step();
        chk("rst2_count", fifo_count, 2'd0);
        chk("rst2_valid", fetch_valid, 1'b0);
        chk("rst2_halted", halted, 1'b0);
        chk("rst2_pc_out", pc_out, 16'h0000);
        reset       = 1'b0;
        fetch_ready = 1'b1;
        step();
        chk_head("post_rst", 1'b1, 16'h0000, 10'h055);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
